// File: rtl/axi4_write_arbiter_if.sv
// AXI4 write channel bundle (AW/W/B) shared by the arbiter's requester and output ports.
// ID_W is 3 on the requester side; the output side carries one extra routing bit.
interface axi4_write_arbiter_if #(
    parameter int ID_W = 3
);
    logic            aw_valid;
    logic            aw_ready;
    logic [ID_W-1:0] aw_bits_id;
    logic [31:0]     aw_bits_addr;
    logic [7:0]      aw_bits_len;
    logic [2:0]      aw_bits_size;
    logic [1:0]      aw_bits_burst;
    logic [3:0]      aw_bits_echo_tl_state_size;
    logic [3:0]      aw_bits_echo_tl_state_source;

    logic            w_valid;
    logic            w_ready;
    logic [63:0]     w_bits_data;
    logic [7:0]      w_bits_strb;
    logic            w_bits_last;

    logic            b_valid;
    logic            b_ready;
    logic [ID_W-1:0] b_bits_id;
    logic [1:0]      b_bits_resp;
    logic [3:0]      b_bits_echo_tl_state_size;
    logic [3:0]      b_bits_echo_tl_state_source;

    modport master (
        output aw_valid, aw_bits_id, aw_bits_addr, aw_bits_len, aw_bits_size, aw_bits_burst,
               aw_bits_echo_tl_state_size, aw_bits_echo_tl_state_source,
               w_valid, w_bits_data, w_bits_strb, w_bits_last, b_ready,
        input  aw_ready, w_ready, b_valid, b_bits_id, b_bits_resp,
               b_bits_echo_tl_state_size, b_bits_echo_tl_state_source
    );

    modport slave (
        input  aw_valid, aw_bits_id, aw_bits_addr, aw_bits_len, aw_bits_size, aw_bits_burst,
               aw_bits_echo_tl_state_size, aw_bits_echo_tl_state_source,
               w_valid, w_bits_data, w_bits_strb, w_bits_last, b_ready,
        output aw_ready, w_ready, b_valid, b_bits_id, b_bits_resp,
               b_bits_echo_tl_state_size, b_bits_echo_tl_state_source
    );
endinterface

// File: rtl/axi4_write_arbiter.sv
// Two-requester AXI4 write arbiter: round-robin AW grant, W locked to the grant until
// the last beat, B routed back by the top output ID bit, per-requester outstanding limit of 4.
module axi4_write_arbiter (
    input  logic                        clock,
    input  logic                        reset,
    axi4_write_arbiter_if.slave         auto_in_0,
    axi4_write_arbiter_if.slave         auto_in_1,
    axi4_write_arbiter_if.master        auto_out
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state, state_nxt;
    logic            grant, grant_nxt;
    logic            last_grant, last_grant_nxt;
    logic [1:0][2:0] outstanding;
    logic [1:0]      eligible;
    logic [1:0]      aw_hs;
    logic [1:0]      b_hs;
    logic            aw_fire;
    logic            w_fire;
    logic            b_port;

    assign eligible[0] = auto_in_0.aw_valid && (outstanding[0] < 3'd4);
    assign eligible[1] = auto_in_1.aw_valid && (outstanding[1] < 3'd4);

    // AW/W payload always follows the grant; only valid/ready are state-gated.
    assign auto_out.aw_bits_id    = {grant, grant ? auto_in_1.aw_bits_id : auto_in_0.aw_bits_id};
    assign auto_out.aw_bits_addr  = grant ? auto_in_1.aw_bits_addr  : auto_in_0.aw_bits_addr;
    assign auto_out.aw_bits_len   = grant ? auto_in_1.aw_bits_len   : auto_in_0.aw_bits_len;
    assign auto_out.aw_bits_size  = grant ? auto_in_1.aw_bits_size  : auto_in_0.aw_bits_size;
    assign auto_out.aw_bits_burst = grant ? auto_in_1.aw_bits_burst : auto_in_0.aw_bits_burst;
    assign auto_out.aw_bits_echo_tl_state_size =
        grant ? auto_in_1.aw_bits_echo_tl_state_size : auto_in_0.aw_bits_echo_tl_state_size;
    assign auto_out.aw_bits_echo_tl_state_source =
        grant ? auto_in_1.aw_bits_echo_tl_state_source : auto_in_0.aw_bits_echo_tl_state_source;
    assign auto_out.w_bits_data   = grant ? auto_in_1.w_bits_data : auto_in_0.w_bits_data;
    assign auto_out.w_bits_strb   = grant ? auto_in_1.w_bits_strb : auto_in_0.w_bits_strb;
    assign auto_out.w_bits_last   = grant ? auto_in_1.w_bits_last : auto_in_0.w_bits_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        grant_nxt          = grant;
        last_grant_nxt     = last_grant;
        auto_out.aw_valid  = 1'b0;
        auto_out.w_valid   = 1'b0;
        auto_in_0.aw_ready = 1'b0;
        auto_in_1.aw_ready = 1'b0;
        auto_in_0.w_ready  = 1'b0;
        auto_in_1.w_ready  = 1'b0;
        aw_fire            = 1'b0;
        w_fire             = 1'b0;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    grant_nxt      = (&eligible) ? ~last_grant : eligible[1];
                    last_grant_nxt = grant_nxt;
                    state_nxt      = ADDR;
                end
            end
            ADDR: begin
                auto_out.aw_valid  = grant ? auto_in_1.aw_valid : auto_in_0.aw_valid;
                auto_in_0.aw_ready = !grant && auto_out.aw_ready;
                auto_in_1.aw_ready = grant && auto_out.aw_ready;
                aw_fire            = (grant ? auto_in_1.aw_valid : auto_in_0.aw_valid) && auto_out.aw_ready;
                if (aw_fire) state_nxt = DATA;
            end
            DATA: begin
                auto_out.w_valid  = grant ? auto_in_1.w_valid : auto_in_0.w_valid;
                auto_in_0.w_ready = !grant && auto_out.w_ready;
                auto_in_1.w_ready = grant && auto_out.w_ready;
                w_fire            = (grant ? auto_in_1.w_valid : auto_in_0.w_valid) && auto_out.w_ready;
                if (w_fire && auto_out.w_bits_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign aw_hs = {aw_fire && grant, aw_fire && !grant};

    // B path is purely combinational and independent of the FSM.
    assign b_port = auto_out.b_bits_id[3];
    assign auto_in_0.b_valid = auto_out.b_valid && !b_port;
    assign auto_in_1.b_valid = auto_out.b_valid && b_port;
    assign auto_in_0.b_bits_id = auto_out.b_bits_id[2:0];
    assign auto_in_1.b_bits_id = auto_out.b_bits_id[2:0];
    assign auto_in_0.b_bits_resp = auto_out.b_bits_resp;
    assign auto_in_1.b_bits_resp = auto_out.b_bits_resp;
    assign auto_in_0.b_bits_echo_tl_state_size   = auto_out.b_bits_echo_tl_state_size;
    assign auto_in_1.b_bits_echo_tl_state_size   = auto_out.b_bits_echo_tl_state_size;
    assign auto_in_0.b_bits_echo_tl_state_source = auto_out.b_bits_echo_tl_state_source;
    assign auto_in_1.b_bits_echo_tl_state_source = auto_out.b_bits_echo_tl_state_source;
    assign auto_out.b_ready = b_port ? auto_in_1.b_ready : auto_in_0.b_ready;
    assign b_hs = {auto_out.b_valid && b_port && auto_in_1.b_ready,
                   auto_out.b_valid && !b_port && auto_in_0.b_ready};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (aw_hs[n] && !b_hs[n] && outstanding[n] != 3'd4)
                    outstanding[n] <= outstanding[n] + 3'd1;
                else if (b_hs[n] && !aw_hs[n] && outstanding[n] != 3'd0)
                    outstanding[n] <= outstanding[n] - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Scoreboard bench for axi4_write_arbiter: requester models feed queued bursts,
// expected output AW/W traffic is queued at stimulus time and checked on each handshake.
module tb_axi4_write_arbiter;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axi4_write_arbiter_if #(.ID_W(3)) in0 ();
    axi4_write_arbiter_if #(.ID_W(3)) in1 ();
    axi4_write_arbiter_if #(.ID_W(4)) bus_out ();

    axi4_write_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .auto_in_0 (in0),
        .auto_in_1 (in1),
        .auto_out  (bus_out)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;

    aw_t rq_aw0[$], rq_aw1[$], exp_aw[$];
    w_t  rq_w0[$],  rq_w1[$],  exp_w[$];
    int  aw_cyc_log[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   w_cnt = 0;
    bit   w_toggle = 1'b0;
    bit   chk_w0_idle = 1'b0;
    logic [1:0] st;

    task automatic drive_reqs();
        if (rq_aw0.size() > 0) begin
            in0.aw_valid = 1'b1;
            in0.aw_bits_id = rq_aw0[0].id[2:0];
            in0.aw_bits_addr = rq_aw0[0].addr;
            in0.aw_bits_len = rq_aw0[0].len;
            in0.aw_bits_size = 3'd3;
            in0.aw_bits_burst = 2'b01;
            in0.aw_bits_echo_tl_state_size = rq_aw0[0].len[3:0];
            in0.aw_bits_echo_tl_state_source = rq_aw0[0].addr[7:4];
        end else in0.aw_valid = 1'b0;
        if (rq_aw1.size() > 0) begin
            in1.aw_valid = 1'b1;
            in1.aw_bits_id = rq_aw1[0].id[2:0];
            in1.aw_bits_addr = rq_aw1[0].addr;
            in1.aw_bits_len = rq_aw1[0].len;
            in1.aw_bits_size = 3'd3;
            in1.aw_bits_burst = 2'b01;
            in1.aw_bits_echo_tl_state_size = rq_aw1[0].len[3:0];
            in1.aw_bits_echo_tl_state_source = rq_aw1[0].addr[7:4];
        end else in1.aw_valid = 1'b0;
        if (rq_w0.size() > 0) begin
            in0.w_valid = 1'b1;
            {in0.w_bits_data, in0.w_bits_strb, in0.w_bits_last} = rq_w0[0];
        end else in0.w_valid = 1'b0;
        if (rq_w1.size() > 0) begin
            in1.w_valid = 1'b1;
            {in1.w_bits_data, in1.w_bits_strb, in1.w_bits_last} = rq_w1[0];
        end else in1.w_valid = 1'b0;
    endtask

    // One clock cycle: drive requester models, sample at negedge, realign to posedge+1.
    task automatic tick();
        aw_t ea;
        w_t  ew;
        drive_reqs();
        if (w_toggle) bus_out.w_ready = ~bus_out.w_ready;
        @(negedge clock);
        if (in0.aw_valid && in0.aw_ready) void'(rq_aw0.pop_front());
        if (in1.aw_valid && in1.aw_ready) void'(rq_aw1.pop_front());
        if (in0.w_valid && in0.w_ready) void'(rq_w0.pop_front());
        if (in1.w_valid && in1.w_ready) void'(rq_w1.pop_front());
        if (chk_w0_idle) begin
            vectors++;
            if (in0.w_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL w0_ready_idle: got %b expected 0 at cycle %0d", in0.w_ready, cyc);
            end
        end
        if (bus_out.aw_valid && bus_out.aw_ready) begin
            aw_cyc_log.push_back(cyc);
            vectors++;
            if (exp_aw.size() == 0) begin
                miscompares++;
                $display("FAIL aw_unexpected: got id=%h addr=%h expected no AW", bus_out.aw_bits_id, bus_out.aw_bits_addr);
            end else begin
                ea = exp_aw.pop_front();
                if ({bus_out.aw_bits_id, bus_out.aw_bits_addr, bus_out.aw_bits_len, bus_out.aw_bits_size,
                     bus_out.aw_bits_burst, bus_out.aw_bits_echo_tl_state_size, bus_out.aw_bits_echo_tl_state_source}
                    !== {ea.id, ea.addr, ea.len, 3'd3, 2'b01, ea.len[3:0], ea.addr[7:4]}) begin
                    miscompares++;
                    $display("FAIL aw_payload: got id=%h addr=%h len=%h size=%h burst=%h echo=%h/%h expected id=%h addr=%h len=%h size=3 burst=1 echo=%h/%h",
                             bus_out.aw_bits_id, bus_out.aw_bits_addr, bus_out.aw_bits_len, bus_out.aw_bits_size,
                             bus_out.aw_bits_burst, bus_out.aw_bits_echo_tl_state_size, bus_out.aw_bits_echo_tl_state_source,
                             ea.id, ea.addr, ea.len, ea.len[3:0], ea.addr[7:4]);
                end
            end
        end
        if (bus_out.w_valid && bus_out.w_ready) begin
            w_cnt++;
            vectors++;
            if (exp_w.size() == 0) begin
                miscompares++;
                $display("FAIL w_unexpected: got data=%h expected no W beat", bus_out.w_bits_data);
            end else begin
                ew = exp_w.pop_front();
                if ({bus_out.w_bits_data, bus_out.w_bits_strb, bus_out.w_bits_last} !== ew) begin
                    miscompares++;
                    $display("FAIL w_beat: got data=%h strb=%h last=%b expected data=%h strb=%h last=%b",
                             bus_out.w_bits_data, bus_out.w_bits_strb, bus_out.w_bits_last, ew.data, ew.strb, ew.last);
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send(input bit n, input logic [2:0] id, input logic [31:0] addr, input int beats);
        aw_t a;
        w_t  w;
        a.id = {n, id};
        a.addr = addr;
        a.len = 8'(beats - 1);
        if (n) rq_aw1.push_back(a); else rq_aw0.push_back(a);
        exp_aw.push_back(a);
        for (int b = 0; b < beats; b++) begin
            w.data = {addr, 16'hA5A5, 8'(b), 7'd0, n};
            w.strb = 8'(8'hFF >> (b % 8));
            w.last = (b == beats - 1);
            if (n) rq_w1.push_back(w); else rq_w0.push_back(w);
            exp_w.push_back(w);
        end
    endtask

    task automatic clear_tb_state();
        rq_aw0.delete(); rq_aw1.delete(); exp_aw.delete();
        rq_w0.delete(); rq_w1.delete(); exp_w.delete();
        aw_cyc_log.delete();
        in0.aw_valid = 1'b0; in0.w_valid = 1'b0; in0.b_ready = 1'b0;
        in1.aw_valid = 1'b0; in1.w_valid = 1'b0; in1.b_ready = 1'b0;
        bus_out.aw_ready = 1'b0; bus_out.w_ready = 1'b0; bus_out.b_valid = 1'b0;
        bus_out.b_bits_id = '0; bus_out.b_bits_resp = '0;
        bus_out.b_bits_echo_tl_state_size = '0; bus_out.b_bits_echo_tl_state_source = '0;
        w_toggle = 1'b0;
        chk_w0_idle = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_tb_state();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input int budget, input string name);
        for (int k = 0; k < budget && (exp_aw.size() != 0 || exp_w.size() != 0); k++) tick();
        vectors++;
        if (exp_aw.size() != 0 || exp_w.size() != 0) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d AW/%0d W pending expected 0/0", name, exp_aw.size(), exp_w.size());
        end
    endtask

    task automatic check_cnt(input int n, input logic [2:0] exp, input string name);
        logic [2:0] got;
        got = dut.outstanding[n];
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: outstanding[%0d] got %0d expected %0d", name, n, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_tb_state();
        tick();
        st = dut.state;
        vectors++;
        if ({bus_out.aw_valid, bus_out.w_valid, in0.aw_ready, in0.w_ready, in1.aw_ready, in1.w_ready, st} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got awv=%b wv=%b rdy=%b%b%b%b state=%0d expected all 0",
                     bus_out.aw_valid, bus_out.w_valid, in0.aw_ready, in0.w_ready, in1.aw_ready, in1.w_ready, st);
        end
        check_cnt(0, 3'd0, "reset_cnt0");
        check_cnt(1, 3'd0, "reset_cnt1");
        tick();
        reset = 1'b0;
    endtask

    task automatic test_first_tie();
        send(1'b0, 3'h5, 32'h1000_0040, 1);
        send(1'b1, 3'h2, 32'h2000_0080, 1);
        bus_out.aw_ready = 1'b1;
        bus_out.w_ready = 1'b1;
        drain(20, "tie");
        vectors++;
        if (aw_cyc_log.size() != 2 || aw_cyc_log[1] - aw_cyc_log[0] != 3) begin
            miscompares++;
            $display("FAIL tie_spacing: got %0d AWs spacing %0d expected 2 AWs spacing 3", aw_cyc_log.size(),
                     aw_cyc_log.size() == 2 ? aw_cyc_log[1] - aw_cyc_log[0] : -1);
        end
    endtask

    task automatic test_b_route();
        bus_out.b_valid = 1'b1;
        bus_out.b_bits_id = 4'b1010;
        bus_out.b_bits_resp = 2'b10;
        bus_out.b_bits_echo_tl_state_size = 4'h7;
        bus_out.b_bits_echo_tl_state_source = 4'h9;
        in1.b_ready = 1'b1;
        in0.b_ready = 1'b0;
        #1;
        vectors++;
        if ({in1.b_valid, in1.b_bits_id, in1.b_bits_resp, in1.b_bits_echo_tl_state_size,
             in1.b_bits_echo_tl_state_source, in0.b_valid, bus_out.b_ready} !== {1'b1, 3'b010, 2'b10, 4'h7, 4'h9, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL b_route: got v1=%b id=%b resp=%b echo=%h/%h v0=%b rdy=%b expected v1=1 id=010 resp=10 echo=7/9 v0=0 rdy=1",
                     in1.b_valid, in1.b_bits_id, in1.b_bits_resp, in1.b_bits_echo_tl_state_size,
                     in1.b_bits_echo_tl_state_source, in0.b_valid, bus_out.b_ready);
        end
        tick();
        bus_out.b_valid = 1'b0;
        in1.b_ready = 1'b0;
        check_cnt(1, 3'd0, "b_route_cnt1");
        check_cnt(0, 3'd1, "b_route_cnt0");
    endtask

    task automatic test_w_toggle();
        int start;
        do_reset();
        send(1'b1, 3'h3, 32'h3000_0100, 4);
        bus_out.aw_ready = 1'b1;
        bus_out.w_ready = 1'b0;
        w_toggle = 1'b1;
        chk_w0_idle = 1'b1;
        start = w_cnt;
        drain(40, "wtoggle");
        st = dut.state;
        vectors++;
        if (w_cnt - start != 4 || st !== ST_IDLE) begin
            miscompares++;
            $display("FAIL wtoggle_end: got beats=%0d state=%0d expected beats=4 state=%0d", w_cnt - start, st, ST_IDLE);
        end
        tick();
        chk_w0_idle = 1'b0;
        w_toggle = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        int b_cyc;
        do_reset();
        bus_out.aw_ready = 1'b1;
        bus_out.w_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b0, 3'(i), 32'h4000_0000 + 32'(i * 16), 1);
        for (int k = 0; k < 60 && (exp_aw.size() != 1 || exp_w.size() != 1); k++) tick();
        check_cnt(0, 3'd4, "limit_cnt_full");
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (bus_out.aw_valid !== 1'b0 || exp_aw.size() != 1) begin
                miscompares++;
                $display("FAIL limit_stall: got aw_valid=%b pending=%0d expected aw_valid=0 pending=1", bus_out.aw_valid, exp_aw.size());
            end
        end
        bus_out.b_valid = 1'b1;
        bus_out.b_bits_id = 4'b0011;
        in0.b_ready = 1'b1;
        b_cyc = cyc;
        tick();
        bus_out.b_valid = 1'b0;
        in0.b_ready = 1'b0;
        drain(20, "limit");
        vectors++;
        if (aw_cyc_log.size() != 5 || aw_cyc_log[4] - b_cyc != 2) begin
            miscompares++;
            $display("FAIL limit_release: got %0d AWs latency %0d expected 5 AWs latency 2", aw_cyc_log.size(),
                     aw_cyc_log.size() == 5 ? aw_cyc_log[4] - b_cyc : -1);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        bus_out.aw_ready = 1'b1;
        bus_out.w_ready = 1'b1;
        send(1'b0, 3'h1, 32'h5000_0000, 1);
        drain(20, "same_pre");
        bus_out.aw_ready = 1'b0;
        send(1'b0, 3'h2, 32'h5000_0010, 1);
        for (int k = 0; k < 10; k++) begin
            st = dut.state;
            if (st == ST_ADDR && bus_out.aw_valid) break;
            tick();
        end
        bus_out.aw_ready = 1'b1;
        bus_out.b_valid = 1'b1;
        bus_out.b_bits_id = 4'b0001;
        in0.b_ready = 1'b1;
        tick();
        bus_out.b_valid = 1'b0;
        in0.b_ready = 1'b0;
        vectors++;
        if (exp_aw.size() != 0) begin
            miscompares++;
            $display("FAIL same_aw: got %0d AW pending expected 0", exp_aw.size());
        end
        check_cnt(0, 3'd1, "same_cycle_cnt");
        drain(20, "same");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus_out.aw_ready = 1'b1;
        bus_out.w_ready = 1'b1;
        send(1'b1, 3'h6, 32'h6000_0000, 8);
        for (int k = 0; k < 20 && exp_w.size() != 7; k++) tick();
        vectors++;
        if (bus_out.w_valid !== 1'b1 || exp_w.size() != 7) begin
            miscompares++;
            $display("FAIL midrst_pre: got w_valid=%b pending=%0d expected w_valid=1 pending=7", bus_out.w_valid, exp_w.size());
        end
        #2 reset = 1'b1;
        #1;
        st = dut.state;
        vectors++;
        if ({bus_out.aw_valid, bus_out.w_valid, in1.w_ready, in1.aw_ready, st} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrst_async: got awv=%b wv=%b wr1=%b awr1=%b state=%0d expected all 0",
                     bus_out.aw_valid, bus_out.w_valid, in1.w_ready, in1.aw_ready, st);
        end
        check_cnt(1, 3'd0, "midrst_cnt1");
        clear_tb_state();
        tick();
        tick();
        reset = 1'b0;
        bus_out.b_valid = 1'b1;
        bus_out.b_bits_id = 4'b1000;
        in1.b_ready = 1'b1;
        #1;
        vectors++;
        if (in1.b_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_b: got b_valid1=%b expected 1", in1.b_valid);
        end
        tick();
        bus_out.b_valid = 1'b0;
        in1.b_ready = 1'b0;
        check_cnt(1, 3'd0, "midrst_no_underflow");
        for (int k = 0; k < 4; k++) tick();
    endtask

    initial begin
        test_reset();
        test_first_tie();
        test_b_route();
        test_w_toggle();
        test_outstanding_limit();
        test_same_cycle();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
